cmd_assembler: RTL and testbench
================================

// Module: cmd_assembler
// PURPOSE
//  Sits between the UART byte transceiver and the command config block. Assembles
//  3-byte remote frames (opcode, data[15:8], data[7:0]) into cmd/data and presents
//  them with a cmd_rdy/clr_cmd_rdy handshake. Sends the single-byte response back
//  through the UART transmitter. An inter-byte timeout resynchronises broken frames.
// PARAMETERS
//  TMO_CYCLES  1_000_000  inter-byte timeout in clk cycles (20 ms @ 50 MHz); bench uses 64
//  TMO_W       $clog2(TMO_CYCLES+1)  timeout counter width (derived, do not override)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   reset, asynchronous, active-low
//  rx_rdy       in   1   UART receiver holds a valid byte
//  rx_data      in   8   received byte
//  clr_rx_rdy   out  1   byte consumed; knocks down rx_rdy
//  cmd_rdy      out  1   complete frame valid on cmd/data
//  cmd          out  8   frame opcode
//  data         out  16  frame payload, {byte1,byte2}
//  clr_cmd_rdy  in   1   consumer done with frame
//  send_resp    in   1   1-cycle request to transmit resp
//  resp         in   8   response byte (normally 8'hA5)
//  trmt         out  1   1-cycle start pulse to UART transmitter
//  tx_data      out  8   byte to transmit
//  tx_done      in   1   transmitter finished current byte
//  resp_sent    out  1   1-cycle pulse: response fully transmitted
//  frm_err      out  1   1-cycle pulse: partial frame dropped on timeout
// BEHAVIOUR
//  Reset: all outputs 0; cmd=0, data=0, tx_data=0; both FSMs in idle state; timer 0.
//  accept = rx_rdy & ~cmd_rdy. clr_rx_rdy = accept (combinational, same cycle).
//  Byte captured on the clk edge ending the accept cycle.
//  RX FSM: B0 -(accept)-> B1 -(accept)-> B2 -(accept)-> B0.
//   B0: byte -> opcode staging reg. B1: byte -> data_hi staging. B2: byte -> data_lo.
//   On the B2 accept edge: cmd<=staged opcode, data<={staged hi, rx_data}, cmd_rdy<=1.
//   cmd/data change only on frame completion; stable while cmd_rdy=1 and while the
//   next frame assembles.
//  Back-pressure: while cmd_rdy=1 no bytes are accepted; rx_rdy is left pending.
//  cmd_rdy: set on B2 accept edge; cleared on the edge after clr_cmd_rdy=1.
//   clr_cmd_rdy with cmd_rdy=0 has no effect. The earliest next accept is the cycle after the clear.
//  Latency: last byte rx_rdy high at cycle N -> cmd_rdy high from cycle N+1.
//  Timeout: counter cleared in B0 and on every accept. Counts each cycle in B1/B2.
//   When count reaches TMO_CYCLES-1 with no accept: FSM->B0, staging discarded,
//   frm_err=1 for one cycle, cmd/data/cmd_rdy untouched.
//   An accept in the same cycle as the terminal count wins (byte taken, no error).
//  TX FSM: T_IDLE -(send_resp)-> T_BUSY -(tx_done)-> T_IDLE.
//   On send_resp in T_IDLE: tx_data<=resp, trmt=1 next cycle only (registered pulse).
//   In T_BUSY, tx_done -> resp_sent=1 next cycle, return to T_IDLE.
//   send_resp while in T_BUSY is ignored (no queue). tx_done in T_IDLE is ignored.
//   TX and RX FSMs are independent; simultaneous activity is legal.
//  Reset mid-frame or mid-transmit: immediate return to reset values. No pulses emitted.
// TESTING
//  1 bytes 02,01,2C with rx_rdy -> clr_rx_rdy each; cmd_rdy=1, cmd=02, data=012C
//  2 cmd_rdy held, 4th byte 05 offered -> no clr_rx_rdy until clr_cmd_rdy; then accepted;
//    cmd/data stay 02/012C until frame 05,00,80 completes -> cmd=05, data=0080
//  3 bytes 03,FF then silence 64 cycles (TMO_CYCLES=64) -> frm_err pulse;
//    next 04,00,10 -> cmd=04, data=0010
//  4 byte arrives exactly at terminal count -> accepted, no frm_err
//  5 send_resp with resp=A5 -> trmt 1 cycle, tx_data=A5; second send_resp while busy
//    -> no trmt; tx_done -> resp_sent pulse
//  6 rst_n low after 2 bytes of frame -> outputs 0; fresh 08,00,00 -> cmd=08, data=0000

Source files
------------

// File: rtl/cmd_assembler.sv
// Assembles 3-byte UART command frames into cmd/data with a ready/clear handshake.
// Also forwards a single-byte response to the UART transmitter.
module cmd_assembler #(
  parameter int unsigned TMO_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic        cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic [7:0]  resp,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        resp_sent,
  output logic        frm_err
);

  localparam int unsigned TMO_W = $clog2(TMO_CYCLES + 1);

  typedef enum logic [1:0] {StB0, StB1, StB2} rx_state_e;
  typedef enum logic {StTxIdle, StTxBusy} tx_state_e;

  rx_state_e        rx_state_q, rx_state_d;
  tx_state_e        tx_state_q, tx_state_d;
  logic [7:0]       op_q, op_d, hi_q, hi_d;
  logic [7:0]       cmd_q, cmd_d, tx_data_q, tx_data_d;
  logic [15:0]      data_q, data_d;
  logic             cmd_rdy_q, cmd_rdy_d, frm_err_q, frm_err_d;
  logic             trmt_q, trmt_d, resp_sent_q, resp_sent_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             accept, tmo_hit;

  // A waiting frame blocks intake; the byte stays pending in the receiver.
  assign accept  = rx_rdy & ~cmd_rdy_q;
  assign tmo_hit = (tmo_cnt_q == TMO_W'(TMO_CYCLES - 1)) & ~accept;

  always_comb begin
    rx_state_d = rx_state_q;
    op_d       = op_q;
    hi_d       = hi_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    cmd_rdy_d  = cmd_rdy_q;
    frm_err_d  = 1'b0;
    tmo_cnt_d  = tmo_cnt_q + TMO_W'(1);
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
    unique case (rx_state_q)
      StB0: begin
        tmo_cnt_d = '0;
        if (accept) begin
          op_d       = rx_data;
          rx_state_d = StB1;
        end
      end
      StB1, StB2: begin
        if (accept) begin
          tmo_cnt_d = '0;
          if (rx_state_q == StB1) begin
            hi_d       = rx_data;
            rx_state_d = StB2;
          end else begin
            cmd_d      = op_q;
            data_d     = {hi_q, rx_data};
            cmd_rdy_d  = 1'b1;
            rx_state_d = StB0;
          end
        end else if (tmo_hit) begin
          tmo_cnt_d  = '0;
          frm_err_d  = 1'b1;
          rx_state_d = StB0;
        end
      end
      default: begin
        tmo_cnt_d  = '0;
        rx_state_d = StB0;
      end
    endcase
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_data_d   = tx_data_q;
    trmt_d      = 1'b0;
    resp_sent_d = 1'b0;
    unique case (tx_state_q)
      StTxIdle: begin
        if (send_resp) begin
          tx_data_d  = resp;
          trmt_d     = 1'b1;
          tx_state_d = StTxBusy;
        end
      end
      StTxBusy: begin
        if (tx_done) begin
          resp_sent_d = 1'b1;
          tx_state_d  = StTxIdle;
        end
      end
      default: tx_state_d = StTxIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= StB0;
      tx_state_q  <= StTxIdle;
      op_q        <= '0;
      hi_q        <= '0;
      cmd_q       <= '0;
      data_q      <= '0;
      cmd_rdy_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      tmo_cnt_q   <= '0;
      tx_data_q   <= '0;
      trmt_q      <= 1'b0;
      resp_sent_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      tx_state_q  <= tx_state_d;
      op_q        <= op_d;
      hi_q        <= hi_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      cmd_rdy_q   <= cmd_rdy_d;
      frm_err_q   <= frm_err_d;
      tmo_cnt_q   <= tmo_cnt_d;
      tx_data_q   <= tx_data_d;
      trmt_q      <= trmt_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  assign clr_rx_rdy = accept;
  assign cmd_rdy    = cmd_rdy_q;
  assign cmd        = cmd_q;
  assign data       = data_q;
  assign frm_err    = frm_err_q;
  assign trmt       = trmt_q;
  assign tx_data    = tx_data_q;
  assign resp_sent  = resp_sent_q;

endmodule

// File: tb/tb_cmd_assembler.sv
// Directed bench for cmd_assembler: framing, back-pressure, timeout, response path, reset.
module tb_cmd_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_rdy, clr_rx_rdy, cmd_rdy, clr_cmd_rdy;
  logic [7:0]  rx_data, cmd, resp, tx_data;
  logic [15:0] data;
  logic        send_resp, trmt, tx_done, resp_sent, frm_err;

  int   checks = 0;
  int   errors = 0;
  int   frm_err_cnt = 0;
  logic last_clr;

  cmd_assembler #(.TMO_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
    .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .resp(resp), .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
    .resp_sent(resp_sent), .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frm_err === 1'b1) frm_err_cnt <= frm_err_cnt + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Offers one byte for a single cycle and records whether it was taken.
  task automatic offer(input logic [7:0] b);
    rx_rdy = 1'b1; rx_data = b;
    #1 last_clr = clr_rx_rdy;
    @(posedge clk); #1;
    rx_rdy = 1'b0;
  endtask

  task automatic clear_cmd();
    clr_cmd_rdy = 1'b1;
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = '0; clr_cmd_rdy = 1'b0;
    send_resp = 1'b0; resp = '0; tx_done = 1'b0;
    #12;
    checks++;
    if ({cmd_rdy, cmd, data, trmt, tx_data, resp_sent, frm_err, clr_rx_rdy} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h/%h/%h trmt=%b tx=%h rs=%b fe=%b clr=%b want all 0",
               cmd_rdy, cmd, data, trmt, tx_data, resp_sent, frm_err, clr_rx_rdy);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_frame();
    offer(8'h02);
    checks++; if (last_clr !== 1'b1) begin errors++; $display("FAIL t1_clr0 got %b want 1", last_clr); end
    offer(8'h01);
    checks++; if (last_clr !== 1'b1) begin errors++; $display("FAIL t1_clr1 got %b want 1", last_clr); end
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL t1_early_rdy got %b want 0", cmd_rdy); end
    offer(8'h2C);
    checks++; if (last_clr !== 1'b1) begin errors++; $display("FAIL t1_clr2 got %b want 1", last_clr); end
    checks++;
    if ({cmd_rdy, cmd, data} !== {1'b1, 8'h02, 16'h012C}) begin
      errors++; $display("FAIL t1_frame got %b %h %h want 1 02 012c", cmd_rdy, cmd, data);
    end
  endtask

  task automatic test_backpressure();
    rx_rdy = 1'b1; rx_data = 8'h05;
    #1;
    checks++; if (clr_rx_rdy !== 1'b0) begin errors++; $display("FAIL t2_blocked got %b want 0", clr_rx_rdy); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (clr_rx_rdy !== 1'b0 || cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL t2_held clr=%b rdy=%b want 0 1", clr_rx_rdy, cmd_rdy);
    end
    clear_cmd();
    checks++; if (cmd_rdy !== 1'b0 || clr_rx_rdy !== 1'b1) begin
      errors++; $display("FAIL t2_release rdy=%b clr=%b want 0 1", cmd_rdy, clr_rx_rdy);
    end
    @(posedge clk); #1;
    rx_rdy = 1'b0;
    offer(8'h00);
    checks++; if (cmd !== 8'h02 || data !== 16'h012C) begin
      errors++; $display("FAIL t2_stable got %h %h want 02 012c", cmd, data);
    end
    offer(8'h80);
    checks++; if ({cmd_rdy, cmd, data} !== {1'b1, 8'h05, 16'h0080}) begin
      errors++; $display("FAIL t2_frame got %b %h %h want 1 05 0080", cmd_rdy, cmd, data);
    end
    clear_cmd();
  endtask

  task automatic test_timeout();
    offer(8'h03);
    offer(8'hFF);
    repeat (63) @(posedge clk);
    #1;
    checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL t3_early_err got %b want 0", frm_err); end
    @(posedge clk); #1;
    checks++; if (frm_err !== 1'b1) begin errors++; $display("FAIL t3_err got %b want 1", frm_err); end
    checks++; if ({cmd_rdy, cmd, data} !== {1'b0, 8'h05, 16'h0080}) begin
      errors++; $display("FAIL t3_untouched got %b %h %h want 0 05 0080", cmd_rdy, cmd, data);
    end
    @(posedge clk); #1;
    checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL t3_err_len got %b want 0", frm_err); end
    offer(8'h04); offer(8'h00); offer(8'h10);
    checks++; if ({cmd_rdy, cmd, data} !== {1'b1, 8'h04, 16'h0010}) begin
      errors++; $display("FAIL t3_resync got %b %h %h want 1 04 0010", cmd_rdy, cmd, data);
    end
    clear_cmd();
  endtask

  task automatic test_terminal_count();
    int errs_before;
    errs_before = frm_err_cnt;
    offer(8'h06);
    repeat (63) @(posedge clk);
    #1;
    offer(8'h07);
    checks++; if (last_clr !== 1'b1) begin errors++; $display("FAIL t4_taken got %b want 1", last_clr); end
    offer(8'h09);
    checks++; if ({cmd_rdy, cmd, data} !== {1'b1, 8'h06, 16'h0709}) begin
      errors++; $display("FAIL t4_frame got %b %h %h want 1 06 0709", cmd_rdy, cmd, data);
    end
    checks++; if (frm_err_cnt !== errs_before) begin
      errors++; $display("FAIL t4_no_err got %0d want %0d", frm_err_cnt, errs_before);
    end
    clear_cmd();
  endtask

  task automatic test_resp();
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    checks++; if (resp_sent !== 1'b0) begin errors++; $display("FAIL t5_idle_done got %b want 0", resp_sent); end
    send_resp = 1'b1; resp = 8'hA5;
    @(posedge clk); #1;
    send_resp = 1'b0;
    checks++; if (trmt !== 1'b1 || tx_data !== 8'hA5) begin
      errors++; $display("FAIL t5_trmt got %b %h want 1 a5", trmt, tx_data);
    end
    send_resp = 1'b1; resp = 8'h3C;
    @(posedge clk); #1;
    send_resp = 1'b0;
    checks++; if (trmt !== 1'b0 || tx_data !== 8'hA5) begin
      errors++; $display("FAIL t5_busy_ignore got %b %h want 0 a5", trmt, tx_data);
    end
    @(posedge clk); #1;
    checks++; if (trmt !== 1'b0) begin errors++; $display("FAIL t5_no_retrmt got %b want 0", trmt); end
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    checks++; if (resp_sent !== 1'b1) begin errors++; $display("FAIL t5_sent got %b want 1", resp_sent); end
    @(posedge clk); #1;
    checks++; if (resp_sent !== 1'b0) begin errors++; $display("FAIL t5_sent_len got %b want 0", resp_sent); end
  endtask

  task automatic test_mid_reset();
    offer(8'h0A); offer(8'h0B);
    rst_n = 1'b0;
    #1;
    checks++; if ({cmd_rdy, cmd, data, frm_err, trmt, resp_sent} !== 28'd0) begin
      errors++; $display("FAIL t6_reset got %b %h %h fe=%b want 0 00 0000 0", cmd_rdy, cmd, data, frm_err);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    offer(8'h08); offer(8'h00); offer(8'h00);
    checks++; if ({cmd_rdy, cmd, data} !== {1'b1, 8'h08, 16'h0000}) begin
      errors++; $display("FAIL t6_frame got %b %h %h want 1 08 0000", cmd_rdy, cmd, data);
    end
    checks++; if (frm_err_cnt !== 1) begin
      errors++; $display("FAIL frm_err_total got %0d want 1", frm_err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_timeout();
    test_terminal_count();
    test_resp();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
